// File: rtl/playfield_tile_mapper.sv
// playfield_tile_mapper
//
// Converts the VGA beam position into playfield tile coordinates for the
// background and sprite ROM lookups. Each tile row can scroll horizontally.
// A row's scroll offset wraps modulo the playfield width. The result is
// registered, so there is exactly one cycle of latency.
//
// Ports:
//   clk            pixel clock
//   reset          asynchronous, active-high; clears outputs and scroll state
//   global_pixel_x beam x (10 bit)
//   global_pixel_y beam y (10 bit)
//   frame_tick     one pulse per frame; SPEED_DIV pulses make one scroll step
//   scroll_clr     synchronous clear of divider and all row offsets
//   obj_pixel_x    x inside the tile (after scrolling)
//   obj_pixel_y    y inside the tile
//   tile_col       tile column (after scrolling)
//   tile_row       tile row
//   in_field       beam lies inside the playfield
module playfield_tile_mapper #(
    parameter int              TILE_BITS     = 5,
    parameter int              ORIGIN_X      = 96,
    parameter int              ORIGIN_Y      = 64,
    parameter int              COLS          = 14,
    parameter int              ROWS          = 12,
    parameter int              SPEED_DIV     = 2,
    parameter logic [ROWS-1:0] ROW_SCROLL_EN = '0,
    parameter logic [ROWS-1:0] ROW_DIR_LEFT  = '0,
    localparam int             COL_W         = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int             ROW_W         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           global_pixel_x,
    input  logic [9:0]           global_pixel_y,
    input  logic                 frame_tick,
    input  logic                 scroll_clr,
    output logic [TILE_BITS-1:0] obj_pixel_x,
    output logic [TILE_BITS-1:0] obj_pixel_y,
    output logic [COL_W-1:0]     tile_col,
    output logic [ROW_W-1:0]     tile_row,
    output logic                 in_field
);

    localparam int FIELD_W = COLS << TILE_BITS;
    localparam int FIELD_H = ROWS << TILE_BITS;
    localparam int OFF_W   = $clog2(FIELD_W);
    localparam int DIV_W   = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;

    localparam logic [9:0]       X_LO      = 10'(ORIGIN_X);
    localparam logic [9:0]       X_HI      = 10'(ORIGIN_X + FIELD_W);
    localparam logic [9:0]       Y_LO      = 10'(ORIGIN_Y);
    localparam logic [9:0]       Y_HI      = 10'(ORIGIN_Y + FIELD_H);
    localparam logic [10:0]      FIELD_W11 = 11'(FIELD_W);
    localparam logic [OFF_W-1:0] OFF_MAX   = OFF_W'(FIELD_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SPEED_DIV - 1);

    // ------------------------------------------------------------------
    // Scroll divider: a step fires on the tick that wraps the divider.
    // A clear on the same cycle wins, and that tick is discarded.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_reg;
    logic             step;

    assign step = frame_tick && !scroll_clr && (div_reg == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg <= '0;
        end else if (scroll_clr) begin
            div_reg <= '0;
        end else if (frame_tick) begin
            div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-row offset registers. Only scrolling rows get storage.
    // Static rows are tied to zero.
    // ------------------------------------------------------------------
    logic [OFF_W-1:0] row_offset [ROWS];

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        if (ROW_SCROLL_EN[gi]) begin : g_scroll
            localparam bit DIR_LEFT = ROW_DIR_LEFT[gi];

            logic [OFF_W-1:0] offset_reg;
            logic [OFF_W-1:0] offset_next;

            always_comb begin
                offset_next = offset_reg;
                if (scroll_clr) begin
                    offset_next = '0;
                end else if (step) begin
                    if (DIR_LEFT) begin
                        offset_next = (offset_reg == OFF_MAX) ? '0 : offset_reg + OFF_W'(1);
                    end else begin
                        offset_next = (offset_reg == '0) ? OFF_MAX : offset_reg - OFF_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    offset_reg <= '0;
                end else begin
                    offset_reg <= offset_next;
                end
            end

            assign row_offset[gi] = offset_reg;
        end else begin : g_fixed
            assign row_offset[gi] = '0;
        end
    end

    // ------------------------------------------------------------------
    // Coordinate mapping (combinational), registered below.
    // ------------------------------------------------------------------
    logic                 in_field_c;
    logic [9:0]           rel_x;
    logic [9:0]           rel_y;
    logic [9:0]           row_full;
    logic [OFF_W-1:0]     sel_offset;
    logic [10:0]          field_sum;
    logic [10:0]          field_x;
    logic [TILE_BITS-1:0] obj_pixel_x_next;
    logic [TILE_BITS-1:0] obj_pixel_y_next;
    logic [COL_W-1:0]     tile_col_next;
    logic [ROW_W-1:0]     tile_row_next;

    always_comb begin
        in_field_c = (global_pixel_x >= X_LO) && (global_pixel_x < X_HI) &&
                     (global_pixel_y >= Y_LO) && (global_pixel_y < Y_HI);
        rel_x      = global_pixel_x - X_LO;
        rel_y      = global_pixel_y - Y_LO;
        row_full   = rel_y >> TILE_BITS;

        // Row out of range only happens outside the field. In that case
        // the offset is zero, and the outputs are forced to zero anyway.
        sel_offset = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_full == 10'(r)) begin
                sel_offset = row_offset[r];
            end
        end

        // Both terms are below FIELD_W, so one conditional subtract
        // completes the modulo.
        field_sum = {1'b0, rel_x} + {{(11 - OFF_W){1'b0}}, sel_offset};
        field_x   = (field_sum >= FIELD_W11) ? field_sum - FIELD_W11 : field_sum;

        obj_pixel_x_next = '0;
        obj_pixel_y_next = '0;
        tile_col_next    = '0;
        tile_row_next    = '0;
        if (in_field_c) begin
            obj_pixel_x_next = field_x[TILE_BITS-1:0];
            obj_pixel_y_next = rel_y[TILE_BITS-1:0];
            tile_col_next    = COL_W'(field_x >> TILE_BITS);
            tile_row_next    = ROW_W'(row_full);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            obj_pixel_x <= '0;
            obj_pixel_y <= '0;
            tile_col    <= '0;
            tile_row    <= '0;
            in_field    <= 1'b0;
        end else begin
            obj_pixel_x <= obj_pixel_x_next;
            obj_pixel_y <= obj_pixel_y_next;
            tile_col    <= tile_col_next;
            tile_row    <= tile_row_next;
            in_field    <= in_field_c;
        end
    end

endmodule

// File: tb/tb_playfield_tile_mapper.sv
// Testbench for playfield_tile_mapper.
// A behavioural model uses plain modulo arithmetic to predict each output
// word. That prediction is compared with the DUT on every cycle. Directed
// literal expectations pin down the model at the boundaries and in the
// scroll scenarios.
module tb_playfield_tile_mapper;

    localparam int TILE_BITS = 5;
    localparam int ORIGIN_X  = 96;
    localparam int ORIGIN_Y  = 64;
    localparam int COLS      = 14;
    localparam int ROWS      = 12;
    localparam int SPEED_DIV = 2;
    localparam logic [11:0] SCROLL_EN = 12'b1000_0010_0111;
    localparam logic [11:0] DIR_LEFT  = 12'b1000_0000_0101;
    localparam int TILE = 1 << TILE_BITS;
    localparam int FW   = COLS * TILE;
    localparam int FH   = ROWS * TILE;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] global_pixel_x;
    logic [9:0] global_pixel_y;
    logic       frame_tick;
    logic       scroll_clr;
    logic [4:0] obj_pixel_x;
    logic [4:0] obj_pixel_y;
    logic [3:0] tile_col;
    logic [3:0] tile_row;
    logic       in_field;

    playfield_tile_mapper #(
        .TILE_BITS    (TILE_BITS),
        .ORIGIN_X     (ORIGIN_X),
        .ORIGIN_Y     (ORIGIN_Y),
        .COLS         (COLS),
        .ROWS         (ROWS),
        .SPEED_DIV    (SPEED_DIV),
        .ROW_SCROLL_EN(SCROLL_EN),
        .ROW_DIR_LEFT (DIR_LEFT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .global_pixel_x(global_pixel_x),
        .global_pixel_y(global_pixel_y),
        .frame_tick    (frame_tick),
        .scroll_clr    (scroll_clr),
        .obj_pixel_x   (obj_pixel_x),
        .obj_pixel_y   (obj_pixel_y),
        .tile_col      (tile_col),
        .tile_row      (tile_row),
        .in_field      (in_field)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        int in_f;
        int col;
        int row;
        int ox;
        int oy;
    } map_t;

    int         model_div;
    int         model_off [ROWS];
    map_t       exp_map;
    bit         exp_valid = 1'b0;
    logic [11:0] en_mask  = SCROLL_EN;
    logic [11:0] dir_mask = DIR_LEFT;

    function automatic map_t map_model(input int x, input int y);
        map_t m;
        int rx, ry, r, fx;
        m = '0;
        if (x >= ORIGIN_X && x < ORIGIN_X + FW && y >= ORIGIN_Y && y < ORIGIN_Y + FH) begin
            rx     = x - ORIGIN_X;
            ry     = y - ORIGIN_Y;
            r      = ry / TILE;
            fx     = (rx + model_off[r]) % FW;
            m.in_f = 1;
            m.col  = fx / TILE;
            m.ox   = fx % TILE;
            m.row  = r;
            m.oy   = ry % TILE;
        end
        return m;
    endfunction

    function automatic logic [18:0] pack_map(input map_t m);
        return {m.in_f[0], m.col[3:0], m.row[3:0], m.ox[4:0], m.oy[4:0]};
    endfunction

    function automatic logic [18:0] act_vec();
        return {in_field, tile_col, tile_row, obj_pixel_x, obj_pixel_y};
    endfunction

    // Reference model: predicted output for the inputs sampled at each edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_div <= 0;
            for (int r = 0; r < ROWS; r++) model_off[r] <= 0;
            exp_map   <= '0;
            exp_valid <= 1'b1;
        end else begin
            exp_map <= map_model(int'(global_pixel_x), int'(global_pixel_y));
            if (scroll_clr) begin
                model_div <= 0;
                for (int r = 0; r < ROWS; r++) model_off[r] <= 0;
            end else if (frame_tick) begin
                if (model_div == SPEED_DIV - 1) begin
                    model_div <= 0;
                    for (int r = 0; r < ROWS; r++) begin
                        if (en_mask[r]) begin
                            model_off[r] <= dir_mask[r] ? (model_off[r] + 1) % FW
                                                        : (model_off[r] + FW - 1) % FW;
                        end
                    end
                end else begin
                    model_div <= model_div + 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (act_vec() !== pack_map(exp_map)) begin
                $display("FAIL model t=%0t x=%0d y=%0d: got in=%0b col=%0d row=%0d ox=%0d oy=%0d, want in=%0d col=%0d row=%0d ox=%0d oy=%0d",
                         $time, global_pixel_x, global_pixel_y, in_field, tile_col, tile_row,
                         obj_pixel_x, obj_pixel_y, exp_map.in_f, exp_map.col, exp_map.row,
                         exp_map.ox, exp_map.oy);
            end else begin
                passed++;
            end
        end
    end

    task automatic check_lit(input string name, input int fin, input int col, input int row,
                             input int ox, input int oy);
        map_t m;
        m.in_f = fin; m.col = col; m.row = row; m.ox = ox; m.oy = oy;
        checks++;
        if (act_vec() !== pack_map(m)) begin
            $display("FAIL %s: got in=%0b col=%0d row=%0d ox=%0d oy=%0d, want in=%0d col=%0d row=%0d ox=%0d oy=%0d",
                     name, in_field, tile_col, tile_row, obj_pixel_x, obj_pixel_y,
                     fin, col, row, ox, oy);
        end else begin
            passed++;
            $display("ok   %s: in=%0b col=%0d row=%0d ox=%0d oy=%0d",
                     name, in_field, tile_col, tile_row, obj_pixel_x, obj_pixel_y);
        end
    endtask

    // One cycle. Inputs are driven at the negedge. Returns 1 time unit
    // after the sampling edge, so outputs already show this cycle's result.
    task automatic cyc(input int x, input int y, input bit t, input bit c);
        @(negedge clk);
        global_pixel_x = 10'(x);
        global_pixel_y = 10'(y);
        frame_tick     = t;
        scroll_clr     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        reset          = 1'b1;
        frame_tick     = 1'b0;
        scroll_clr     = 1'b0;
        global_pixel_x = '0;
        global_pixel_y = '0;
        repeat (2) @(posedge clk);
        #1;
        check_lit("reset_state", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Origin pixel, then an asynchronous reset in the middle of a line.
        cyc(96, 64, 0, 0);   check_lit("origin", 1, 0, 0, 0, 0);
        cyc(300, 200, 0, 0); check_lit("mid_field", 1, 6, 4, 12, 8);
        #2 reset = 1'b1;
        #1 check_lit("async_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Boundaries with offsets still zero.
        cyc(95, 64, 0, 0);   check_lit("left_edge_out", 0, 0, 0, 0, 0);
        cyc(543, 64, 0, 0);  check_lit("right_edge_in", 1, 13, 0, 31, 0);
        cyc(544, 64, 0, 0);  check_lit("right_edge_out", 0, 0, 0, 0, 0);
        cyc(96, 447, 0, 0);  check_lit("bottom_edge_in", 1, 0, 11, 0, 31);
        cyc(96, 448, 0, 0);  check_lit("bottom_edge_out", 0, 0, 0, 0, 0);
        cyc(96, 63, 0, 0);   check_lit("top_edge_out", 0, 0, 0, 0, 0);

        // Four ticks with a divider of two give two steps.
        ticks(4);
        cyc(96, 64, 0, 0);   check_lit("row0_left2", 1, 0, 0, 2, 0);
        cyc(543, 64, 0, 0);  check_lit("row0_wrap", 1, 0, 0, 1, 0);
        cyc(96, 160, 0, 0);  check_lit("row3_static", 1, 0, 3, 0, 0);
        cyc(96, 96, 0, 0);   check_lit("row1_right2", 1, 13, 1, 30, 0);

        // Clear, then two ticks give one step, so row 1 sits at 447.
        cyc(0, 0, 0, 1);
        ticks(2);
        cyc(96, 96, 0, 0);   check_lit("row1_447", 1, 13, 1, 31, 0);

        // A clear arriving together with a tick has priority.
        cyc(0, 0, 0, 1);
        ticks(5);
        cyc(96, 64, 0, 0);   check_lit("pre_clr_off2", 1, 0, 0, 2, 0);
        cyc(0, 0, 1, 1);
        cyc(96, 64, 0, 0);   check_lit("clr_priority", 1, 0, 0, 0, 0);
        ticks(1);
        cyc(96, 64, 0, 0);   check_lit("tick_after_clr", 1, 0, 0, 0, 0);
        cyc(96, 128, 0, 0);  check_lit("row2_after_clr", 1, 0, 2, 0, 0);

        // Raster sweep, checked by the model every cycle.
        for (int yi = 0; yi < 480; yi += 13) begin
            for (int x = 0; x < 640; x++) cyc(x, yi, ($urandom_range(0, 63) == 0), 1'b0);
            ticks($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) cyc(0, 0, 0, 1);
        end
        for (int k = 0; k < 5; k++) begin
            int yb;
            case (k)
                0: yb = 63;
                1: yb = 64;
                2: yb = 447;
                3: yb = 448;
                default: yb = 479;
            endcase
            for (int x = 0; x < 640; x++) cyc(x, yb, 1'b0, 1'b0);
            ticks(3);
        end

        cyc(0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
